// File: rtl/perf_report_uart.sv
// perf_report_uart
//   Snapshots the core's five performance counters on a start request and
//   streams them as a fixed frame on a UART 8N1 TX line.
//
//   Binary frame (default, 22 bytes):
//     0xA5, five counters as 32-bit little-endian words (clk_cycles,
//     retired_instructions, predictions_made, correct_predictions,
//     invalid_clk_cycles), then an 8-bit sum of bytes 1..20.
//   ASCII frame (PERF_REPORT_ASCII_EN defined, 45 characters):
//     'P', each payload byte as two upper-case hex characters (high nibble
//     first), the same checksum as two hex characters, then CR LF.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (minimum 2)
// Ports:
//   clk                   system clock
//   rst_n                 asynchronous active-low reset
//   start                 report request, sampled only while idle
//   clk_cycles            core cycle counter (28 bits)
//   retired_instructions  retired count (13 bits)
//   predictions_made      branches resolved (13 bits)
//   correct_predictions   correct predictions (13 bits)
//   invalid_clk_cycles    invalid-slot cycles (13 bits)
//   tx                    UART serial output, idle high, registered
//   busy                  frame in progress
//   done                  one-cycle pulse when the frame ends
`timescale 1ns/1ps
module perf_report_uart #(
  parameter int CLKS_PER_BIT = 651
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] clk_cycles,
  input  logic [12:0] retired_instructions,
  input  logic [12:0] predictions_made,
  input  logic [12:0] correct_predictions,
  input  logic [12:0] invalid_clk_cycles,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef PERF_REPORT_ASCII_EN
  localparam logic [5:0] LAST_IDX = 6'd44;
`else
  localparam logic [5:0] LAST_IDX = 6'd21;
`endif

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA      = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [5:0]       byte_idx;
  logic [7:0]       tx_byte;
  logic [7:0]       checksum;

  logic [27:0] snap_cyc;
  logic [12:0] snap_ret;
  logic [12:0] snap_pred;
  logic [12:0] snap_corr;
  logic [12:0] snap_inv;

  logic        bit_end;
  logic [5:0]  ld_idx;
  logic [5:0]  ofs;
  logic [5:0]  pay_sel;
  logic [31:0] pay_word;
  logic [7:0]  pay_byte;
  logic [7:0]  ld_char;
  logic        ld_add;

`ifdef PERF_REPORT_ASCII_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  assign bit_end = (clk_cnt == CNT_MAX);

  // Character to load next: index 0 when a frame is accepted, otherwise the
  // one after the current index. The checksum register already holds the
  // sum of every payload byte loaded so far when the checksum is loaded.
  always_comb begin
    ld_idx = (state == IDLE) ? '0 : byte_idx + 6'd1;
    ofs    = ld_idx - 6'd1;
`ifdef PERF_REPORT_ASCII_EN
    pay_sel = {1'b0, ofs[5:1]};
`else
    pay_sel = ofs;
`endif
    case (pay_sel[5:2])
      4'd0:    pay_word = {4'h0, snap_cyc};
      4'd1:    pay_word = {19'h0, snap_ret};
      4'd2:    pay_word = {19'h0, snap_pred};
      4'd3:    pay_word = {19'h0, snap_corr};
      default: pay_word = {19'h0, snap_inv};
    endcase
    case (pay_sel[1:0])
      2'd0:    pay_byte = pay_word[7:0];
      2'd1:    pay_byte = pay_word[15:8];
      2'd2:    pay_byte = pay_word[23:16];
      default: pay_byte = pay_word[31:24];
    endcase
`ifdef PERF_REPORT_ASCII_EN
    // Payload byte is accumulated once, when its high-nibble character loads.
    ld_add = (ld_idx >= 6'd1) && (ld_idx <= 6'd40) && !ofs[0];
    case (ld_idx)
      6'd0:    ld_char = 8'h50;
      6'd41:   ld_char = hex_char(checksum[7:4]);
      6'd42:   ld_char = hex_char(checksum[3:0]);
      6'd43:   ld_char = 8'h0D;
      6'd44:   ld_char = 8'h0A;
      default: ld_char = hex_char(ofs[0] ? pay_byte[3:0] : pay_byte[7:4]);
    endcase
`else
    ld_add = (ld_idx >= 6'd1) && (ld_idx <= 6'd20);
    case (ld_idx)
      6'd0:    ld_char = 8'hA5;
      6'd21:   ld_char = checksum;
      default: ld_char = pay_byte;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      tx_byte   <= '0;
      checksum  <= '0;
      snap_cyc  <= '0;
      snap_ret  <= '0;
      snap_pred <= '0;
      snap_corr <= '0;
      snap_inv  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_cyc  <= clk_cycles;
            snap_ret  <= retired_instructions;
            snap_pred <= predictions_made;
            snap_corr <= correct_predictions;
            snap_inv  <= invalid_clk_cycles;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            checksum  <= '0;
            tx_byte   <= ld_char;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START_BIT;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= tx_byte[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              byte_idx <= ld_idx;
              tx_byte  <= ld_char;
              if (ld_add) begin
                checksum <= checksum + pay_byte;
              end
              tx    <= 1'b0;
              state <= START_BIT;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_report_uart.sv
// Scoreboard bench for perf_report_uart (CLKS_PER_BIT = 4). Stimulus pushes
// the expected frame characters; a UART monitor decodes tx and compares.
`timescale 1ns/1ps
module tb_perf_report_uart;

  localparam int CPB = 4;
`ifdef PERF_REPORT_ASCII_EN
  localparam int NCHARS = 45;
`else
  localparam int NCHARS = 22;
`endif
  localparam int FRAME_CYC = NCHARS * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] clk_cycles = '0;
  logic [12:0] retired_instructions = '0;
  logic [12:0] predictions_made = '0;
  logic [12:0] correct_predictions = '0;
  logic [12:0] invalid_clk_cycles = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  perf_report_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .clk_cycles           (clk_cycles),
    .retired_instructions (retired_instructions),
    .predictions_made     (predictions_made),
    .correct_predictions  (correct_predictions),
    .invalid_clk_cycles   (invalid_clk_cycles),
    .tx                   (tx),
    .busy                 (busy),
    .done                 (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_frame(input logic [7:0] b [0:21]);
`ifdef PERF_REPORT_ASCII_EN
    exp_q.push_back(8'h50);
    for (int i = 1; i <= 21; i++) begin
      exp_q.push_back(hexc(b[i][7:4]));
      exp_q.push_back(hexc(b[i][3:0]));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = 0; i <= 21; i++) exp_q.push_back(b[i]);
`endif
  endtask

  task automatic model_frame(input logic [27:0] c, input logic [12:0] r, input logic [12:0] p,
                             input logic [12:0] k, input logic [12:0] v,
                             output logic [7:0] b [0:21]);
    logic [31:0] w [0:4];
    logic [7:0]  s;
    w[0] = {4'h0, c};
    w[1] = {19'h0, r};
    w[2] = {19'h0, p};
    w[3] = {19'h0, k};
    w[4] = {19'h0, v};
    b[0] = 8'hA5;
    s = 8'h00;
    for (int x = 0; x < 5; x++) begin
      for (int l = 0; l < 4; l++) begin
        b[1 + 4*x + l] = w[x][8*l +: 8];
        s = s + w[x][8*l +: 8];
      end
    end
    b[21] = s;
  endtask

  task automatic set_counters(input logic [27:0] c, input logic [12:0] r, input logic [12:0] p,
                              input logic [12:0] k, input logic [12:0] v);
    clk_cycles = c;
    retired_instructions = r;
    predictions_made = p;
    correct_predictions = k;
    invalid_clk_cycles = v;
  endtask

  // Called at the first negedge where busy should be high.
  task automatic wait_frame(input bit scramble, input bit restart);
    int n;
    n = 0;
    while (busy === 1'b1 && n < FRAME_CYC + 100) begin
      n++;
      if (scramble) begin
        clk_cycles = 28'($urandom);
        retired_instructions = 13'($urandom);
        predictions_made = 13'($urandom);
        correct_predictions = 13'($urandom);
        invalid_clk_cycles = 13'($urandom);
        start = (n == 200);
      end
      @(negedge clk);
    end
    check("busy_len", n, FRAME_CYC);
    check("done_pulse", {31'h0, done}, 1);
    check("tx_idle_at_done", {31'h0, tx}, 1);
    if (restart) begin
      @(negedge clk);
      check("restart_busy", {31'h0, busy}, 1);
      check("restart_tx_start", {31'h0, tx}, 0);
      check("restart_pending", exp_q.size(), NCHARS);
      start = 1'b0;
    end else begin
      start = 1'b0;
      @(negedge clk);
      check("done_clear", {31'h0, done}, 0);
      check("busy_clear", {31'h0, busy}, 0);
      check("frame_bytes", exp_q.size(), 0);
    end
  endtask

  task automatic do_frame(input bit scramble);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame(scramble, 1'b0);
  endtask

  // UART monitor: sample each bit at its middle cycle; abandon on reset.
  initial begin
    logic [7:0] d;
    logic       sbit;
    logic       stp;
    bit         ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        d = '0;
        sbit = 1'b1;
        stp = 1'b0;
        for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (c % CPB == CPB/2) begin
            if (c / CPB == 0) sbit = tx;
            else if (c / CPB == 9) stp = tx;
            else d[c/CPB - 1] = tx;
          end
        end
        if (!ab) begin
          check("start_bit", {31'h0, sbit}, 0);
          check("stop_bit", {31'h0, stp}, 1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", d);
          end else begin
            check("byte", {24'h0, d}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fb [0:21];
    int bad;

    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, tx}, 1);
    check("reset_busy", {31'h0, busy}, 0);
    check("reset_done", {31'h0, done}, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_100", bad, 0);

    // Basic frame, hand-computed bytes
    set_counters(28'h10, 13'd5, 13'd2, 13'd1, 13'd3);
    fb = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h1B};
    push_frame(fb);
    do_frame(1'b0);

    // Maximum counter values, hand-computed bytes
    set_counters(28'hFFFFFFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
    fb = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'hFF, 8'h1F,
           8'h00, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'h84};
    push_frame(fb);
    do_frame(1'b0);

    // Snapshot isolation with counters changing and a mid-frame start
    set_counters(28'hABCDEF1, 13'h1234, 13'h0ABC, 13'h0777, 13'h1001);
    model_frame(28'hABCDEF1, 13'h1234, 13'h0ABC, 13'h0777, 13'h1001, fb);
    push_frame(fb);
    do_frame(1'b1);
    repeat (100) @(negedge clk);
    check("no_queued_frame", {31'h0, busy}, 0);
    check("no_extra_bytes", exp_q.size(), 0);

    // Reset mid-frame
    set_counters(28'h0123456, 13'h0042, 13'h0099, 13'h0033, 13'h0011);
    model_frame(28'h0123456, 13'h0042, 13'h0099, 13'h0033, 13'h0011, fb);
    push_frame(fb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    check("busy_before_reset", {31'h0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, tx}, 1);
    check("async_reset_busy", {31'h0, busy}, 0);
    check("async_reset_done", {31'h0, done}, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_resume_busy", {31'h0, busy}, 0);
    check("no_resume_tx", {31'h0, tx}, 1);
    set_counters(28'h7654321, 13'h1ABC, 13'h0DEF, 13'h0CDE, 13'h0005);
    model_frame(28'h7654321, 13'h1ABC, 13'h0DEF, 13'h0CDE, 13'h0005, fb);
    push_frame(fb);
    do_frame(1'b0);

    // start held high: back-to-back frames separated by the done cycle
    set_counters(28'h10, 13'd5, 13'd2, 13'd1, 13'd3);
    model_frame(28'h10, 13'd5, 13'd2, 13'd1, 13'd3, fb);
    push_frame(fb);
    push_frame(fb);
    start = 1'b1;
    @(negedge clk);
    wait_frame(1'b0, 1'b1);
    wait_frame(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_report_uart.md
Name: perf_report_uart

Overview:
- Downstream consumer of the pipelined core's five performance counters: clk_cycles, retired_instructions, predictions_made, correct_predictions and invalid_clk_cycles.
- On a start request it snapshots all five counters in one cycle, then sends them as a fixed binary frame over a UART 8N1 TX line for host-side benchmarking.
- Sits beside the core top level. Its only core-facing interface is the counter buses.

Parameters:
- CLKS_PER_BIT, default 651, clk cycles per UART bit (75 MHz / 115200). Legal minimum is 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a report; sampled only in IDLE
- clk_cycles  in  28  core cycle counter
- retired_instructions  in  13  retired count
- predictions_made  in  13  branches resolved
- correct_predictions  in  13  correct predictions
- invalid_clk_cycles  in  13  invalid-slot cycles
- tx  out  1  UART serial out, idle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, busy=0, done=0.
  - FSM goes to IDLE; bit counter, byte index and checksum are cleared.
  - The snapshot registers are cleared to 0.
  - No partial-frame resumption after reset is released.
- Snapshot:
  - When start=1 in IDLE at edge N, all five counters are latched at edge N.
  - Each counter is zero-extended to 32 bits.
  - Counter changes during the frame do not affect the frame contents.
- Frame byte order (indices 0..21):
  - Byte 0: sync 0xA5.
  - Bytes 1-4: clk_cycles.
  - Bytes 5-8: retired_instructions.
  - Bytes 9-12: predictions_made.
  - Bytes 13-16: correct_predictions.
  - Bytes 17-20: invalid_clk_cycles.
  - Each counter is sent little-endian (LS byte first).
  - Byte 21: checksum = sum of bytes 1..20 mod 256. The sync byte is excluded.
- Per byte: one start bit (0), 8 data bits LSB first, one stop bit (1). Each bit is held for exactly CLKS_PER_BIT cycles.
- No idle gap between bytes: the next start bit follows the stop bit directly.
- FSM states:
  - IDLE -> START_BIT on accepted start.
  - START_BIT -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP_BIT after 8 bits.
  - STOP_BIT -> START_BIT if byte index < 21 (index increments); otherwise STOP_BIT -> IDLE.
- Timing:
  - busy rises and tx falls registered at edge N, so the start bit is visible from cycle N+1.
  - busy stays high for exactly 22*10*CLKS_PER_BIT cycles.
  - On the cycle busy falls, done=1 for exactly one cycle and tx=1.
- start while busy is ignored and not queued.
- start held high continuously:
  - A new frame is accepted on the first IDLE cycle, i.e. the done cycle.
  - Result is one idle-high cycle between frames.
  - Snapshot is re-taken for the new frame.
- Checksum is accumulated with 8-bit wrap as each byte is loaded, not precomputed.
- tx is driven from a flop, so no combinational glitches appear on the line.

Optional Feature:
- Macro PERF_REPORT_ASCII_EN.
- When defined:
  - Each payload byte (bytes 1..20) is sent as two ASCII hex characters, upper nibble first, using '0'-'9' and 'A'-'F'.
  - The sync byte is replaced by ASCII 'P' (0x50).
  - The checksum is sent as two hex characters and computed over the raw binary payload bytes, same as binary mode.
  - The frame is terminated by CR (0x0D) then LF (0x0A).
  - Frame length is 1 + 40 + 2 + 2 = 45 characters.
  - busy lasts 45*10*CLKS_PER_BIT cycles.
- When undefined: 22-byte binary frame as above.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: tx=1, busy=0, done=0 held for 100 cycles with start=0.
- Basic frame: clk_cycles=0x10, retired=5, predictions=2, correct=1, invalid=3; pulse start.
  - Decoded bytes: A5 10 00 00 00 05 00 00 00 02 00 00 00 01 00 00 00 03 00 00 00 1B.
  - busy high exactly 880 cycles, then one done pulse.
- Max values: clk_cycles=0xFFFFFFF, other counters=0x1FFF.
  - Payload: FF FF FF 0F, then FF 1F 00 00 four times.
  - Checksum 0x84.
- Snapshot isolation: counters change every cycle during the frame; decoded values equal those at the start edge. A second start mid-frame produces no extra frame.
- Reset mid-frame (assert at cycle 300): tx=1 and busy=0 immediately (asynchronous). After release, start yields a complete fresh 22-byte frame with correct checksum.
- ASCII build (PERF_REPORT_ASCII_EN), basic-frame values: characters begin "P10000000050000000200…", end "1B\r\n"; 45 characters total.
